// File: rtl/piano_note_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : piano_note_arbiter_if
// Description : Key/speaker bundle between the keyboard pins, the note
//               arbiter and the speaker pin.
//                 keys     - raw key levels, 1 = pressed (asynchronous)
//                 speaker  - square-wave output
//                 active   - 1 while a note is sounding
//                 note_idx - index of the sounding note, 0 when idle
//               master: keyboard/pin side, slave: arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface piano_note_arbiter_if #(
    parameter int NUM_KEYS = 8
);
    localparam int c_IDX_W = $clog2(NUM_KEYS);

    logic [NUM_KEYS-1:0] keys;
    logic                speaker;
    logic                active;
    logic [c_IDX_W-1:0]  note_idx;

    modport master (
        output keys,
        input  speaker,
        input  active,
        input  note_idx
    );

    modport slave (
        input  keys,
        output speaker,
        output active,
        output note_idx
    );
endinterface
`default_nettype wire

// File: rtl/piano_note_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : piano_note_arbiter
// Description : Shares one speaker between eight keys. Raw keys are
//               synchronized, one note is chosen with last-pressed priority,
//               and a single divider toggles the speaker every HALF+1 cycles
//               of the 50 MHz clock.
//               Ports:
//                 clk   - 50 MHz system clock
//                 rst_n - asynchronous active-low reset
//                 bus   - slave side of piano_note_arbiter_if
//                         (keys in; speaker, active, note_idx out)
// Revision    : 1.0 - initial release
// ============================================================================
module piano_note_arbiter #(
    parameter int NUM_KEYS = 8,
    parameter int CNT_W    = 19
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    piano_note_arbiter_if.slave     bus
);
    localparam int c_IDX_W = $clog2(NUM_KEYS);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_PLAY = 1'b1;

    // Counter terminal values for C4 D4 E4 F4 G4 A4 B4 C5 at 50 MHz.
    localparam logic [CNT_W-1:0] c_HALF [0:7] = '{
        CNT_W'(95554), CNT_W'(85131), CNT_W'(75842), CNT_W'(71585),
        CNT_W'(63775), CNT_W'(56817), CNT_W'(50619), CNT_W'(47777)
    };

    logic [NUM_KEYS-1:0] r_ks1;
    logic [NUM_KEYS-1:0] r_ks2;
    logic [NUM_KEYS-1:0] r_ks_d;
    logic [0:0]          r_state;
    logic [c_IDX_W-1:0]  r_note_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_speaker;

    logic [NUM_KEYS-1:0] w_press;
    logic [CNT_W-1:0]    w_half;
    logic [c_IDX_W-1:0]  w_press_top;
    logic [c_IDX_W-1:0]  w_held_top;

    // Highest set bit; ascending scan so the last hit wins.
    function automatic logic [c_IDX_W-1:0] f_top(input logic [NUM_KEYS-1:0] v);
        f_top = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) begin
                f_top = c_IDX_W'(i);
            end
        end
    endfunction

    assign w_press     = r_ks2 & ~r_ks_d;
    assign w_half      = c_HALF[r_note_idx];
    assign w_press_top = f_top(w_press);
    assign w_held_top  = f_top(r_ks2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ks1      <= '0;
            r_ks2      <= '0;
            r_ks_d     <= '0;
            r_state    <= c_IDLE;
            r_note_idx <= '0;
            r_cnt      <= '0;
            r_speaker  <= 1'b0;
        end else begin
            r_ks1  <= bus.keys;
            r_ks2  <= r_ks1;
            r_ks_d <= r_ks2;

            case (r_state)
                c_IDLE: begin
                    r_speaker <= 1'b0;
                    r_cnt     <= '0;
                    if (|w_press) begin
                        r_state    <= c_PLAY;
                        r_note_idx <= w_press_top;
                    end
                end
                c_PLAY: begin
                    if (r_ks2 == '0) begin
                        r_state    <= c_IDLE;
                        r_speaker  <= 1'b0;
                        r_cnt      <= '0;
                        r_note_idx <= '0;
                    end else if (|w_press) begin
                        // Newest press takes over; speaker level is kept so
                        // the note change does not produce an extra edge.
                        r_note_idx <= w_press_top;
                        r_cnt      <= '0;
                    end else if (!r_ks2[r_note_idx]) begin
                        // Sounding key released while others are held.
                        r_note_idx <= w_held_top;
                        r_cnt      <= '0;
                    end else if (r_cnt == w_half) begin
                        r_cnt     <= '0;
                        r_speaker <= ~r_speaker;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.speaker  = r_speaker;
    assign bus.active   = (r_state == c_PLAY);
    assign bus.note_idx = r_note_idx;
endmodule
`default_nettype wire

// File: tb/tb_piano_note_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_piano_note_arbiter
// Description : Self-checking bench for piano_note_arbiter. A vector table
//               walks the note-selection rules; hand sequences cover reset,
//               the first speaker toggle and asynchronous reset mid-note.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piano_note_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    piano_note_arbiter_if #(.NUM_KEYS(8)) bus ();

    piano_note_arbiter #(
        .NUM_KEYS (8),
        .CNT_W    (19)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  keys;
        int          ticks;
        logic        active;
        logic [2:0]  note;
        logic [18:0] cnt;
    } vec_t;

    localparam int c_NVEC = 16;

    int          n_vec  = 0;
    int          n_miss = 0;
    vec_t        vecs [c_NVEC];
    logic [31:0] c_HALF_TB [0:7];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic a, input logic [2:0] n, input logic s);
        n_vec++;
        chk({tag, ".active"},   32'(bus.active),   32'(a));
        chk({tag, ".note_idx"}, 32'(bus.note_idx), 32'(n));
        chk({tag, ".speaker"},  32'(bus.speaker),  32'(s));
    endtask

    initial begin
        c_HALF_TB[0] = 95554; c_HALF_TB[1] = 85131;
        c_HALF_TB[2] = 75842; c_HALF_TB[3] = 71585;
        c_HALF_TB[4] = 63775; c_HALF_TB[5] = 56817;
        c_HALF_TB[6] = 50619; c_HALF_TB[7] = 47777;

        //             keys   tk act note cnt
        vecs[0]  = '{8'h20, 2, 1'b0, 3'd0, 19'd0}; // key 5: not yet
        vecs[1]  = '{8'h20, 1, 1'b1, 3'd5, 19'd0}; // third edge: playing
        vecs[2]  = '{8'h20, 5, 1'b1, 3'd5, 19'd5}; // counter runs
        vecs[3]  = '{8'h01, 3, 1'b1, 3'd0, 19'd0}; // swap 5 -> 0 is a press
        vecs[4]  = '{8'h01, 4, 1'b1, 3'd0, 19'd4};
        vecs[5]  = '{8'h09, 3, 1'b1, 3'd3, 19'd0}; // hold 0, press 3
        vecs[6]  = '{8'h01, 3, 1'b1, 3'd0, 19'd0}; // release 3 -> back to 0
        vecs[7]  = '{8'h00, 2, 1'b1, 3'd0, 19'd2}; // all released, not yet
        vecs[8]  = '{8'h00, 1, 1'b0, 3'd0, 19'd0}; // idle
        vecs[9]  = '{8'h42, 3, 1'b1, 3'd6, 19'd0}; // 1 and 6 together
        vecs[10] = '{8'h02, 3, 1'b1, 3'd1, 19'd0}; // release 6 -> 1
        vecs[11] = '{8'h03, 3, 1'b1, 3'd0, 19'd0}; // press 0
        vecs[12] = '{8'h06, 3, 1'b1, 3'd2, 19'd0}; // press 2 + release 0
        vecs[13] = '{8'h04, 3, 1'b1, 3'd2, 19'd3}; // other key released
        vecs[14] = '{8'h06, 3, 1'b1, 3'd1, 19'd0}; // bounce of key 1
        vecs[15] = '{8'h00, 3, 1'b0, 3'd0, 19'd0}; // idle

        // Reset with every key held.
        rst_n    = 1'b0;
        bus.keys = 8'hFF;
        tick(3);
        chk_out("reset", 1'b0, 3'd0, 1'b0);

        rst_n = 1'b1;
        tick(2);
        chk_out("post_reset_2", 1'b0, 3'd0, 1'b0);
        tick(1);
        chk_out("post_reset_3", 1'b1, 3'd7, 1'b0);

        bus.keys = 8'h00;
        tick(3);
        chk_out("release_all", 1'b0, 3'd0, 1'b0);

        for (int v = 0; v < c_NVEC; v++) begin
            bus.keys = vecs[v].keys;
            tick(vecs[v].ticks);
            chk_out($sformatf("vec%0d", v), vecs[v].active, vecs[v].note, 1'b0);
            chk($sformatf("vec%0d.cnt", v), 32'(dut.r_cnt), 32'(vecs[v].cnt));
            chk($sformatf("vec%0d.half", v), 32'(dut.w_half), c_HALF_TB[vecs[v].note]);
        end

        // First toggle of C5 lands HALF+1 cycles after PLAY entry.
        bus.keys = 8'h80;
        tick(3);
        chk_out("c5_entry", 1'b1, 3'd7, 1'b0);
        tick(100);
        n_vec++;
        chk("c5_cnt100", 32'(dut.r_cnt), 32'd100);
        tick(int'(c_HALF_TB[7]) - 100);
        chk_out("c5_before_toggle", 1'b1, 3'd7, 1'b0);
        tick(1);
        chk_out("c5_toggle", 1'b1, 3'd7, 1'b1);
        n_vec++;
        chk("c5_cnt_wrap", 32'(dut.r_cnt), 32'd0);

        // Asynchronous reset between clock edges while speaker is high.
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 3'd0, 1'b0);
        n_vec++;
        chk("async_reset.cnt", 32'(dut.r_cnt), 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        chk_out("rerelease_2", 1'b0, 3'd0, 1'b0);
        tick(1);
        chk_out("rerelease_3", 1'b1, 3'd7, 1'b0);
        tick(10);
        chk_out("rerelease_run", 1'b1, 3'd7, 1'b0);
        n_vec++;
        chk("rerelease.cnt", 32'(dut.r_cnt), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/piano_note_arbiter.md
# piano_note_arbiter

Shares the single piano speaker between eight key inputs. Synchronizes the raw keys, picks one note with last-pressed priority, looks up that note's half-period, and drives one square-wave divider on `speaker`. It sits between the keyboard pins and the speaker pin and replaces the one-divider-per-note arrangement.

## Interface
- `NUM_KEYS`, 8: number of key inputs. Fixed at 8 in this revision.
- `CNT_W`, 19: divider counter width. Must hold the largest table entry (95554).
- `clk`  input  1  system clock, 50 MHz; the half-period table is valid only at this frequency.
- `rst_n`  input  1  asynchronous, active-low reset.
- `keys`  input  8  raw key levels, 1 = pressed. Asynchronous to `clk`; bit 0 = C4 … bit 7 = C5.
- `speaker`  output  1  square-wave output.
- `active`  output  1  1 while a note is sounding.
- `note_idx`  output  3  index of the sounding note; 0 when idle.

## Operation
- **Synchronizer:** each key bit passes through a 2-flop synchronizer (`ks1`→`ks2`). `ks_d` holds the previous `ks2`.
- **Press detect:** `press = ks2 & ~ks_d`.
- **Half-period table** (`HALF[i]`, counter terminal value): 95554, 85131, 75842, 71585, 63775, 56817, 50619, 47777. These are C4 D4 E4 F4 G4 A4 B4 C5 at 50 MHz.
- **State IDLE:**
  - `active`=0, `speaker`=0, counter=0.
  - If `press`≠0: go to PLAY with `note_idx` = highest set bit of `press`.
- **State PLAY, evaluated in this priority order each cycle:**
  1. `ks2`==0: go to IDLE. `speaker`←0, counter←0, `note_idx`←0.
  2. Else `press`≠0: `note_idx` ← highest set bit of `press` (the most recent press wins). Counter←0; `speaker` keeps its level.
  3. Else `ks2[note_idx]`==0 (current key released, others held): `note_idx` ← highest set bit of `ks2`. Counter←0; `speaker` keeps its level.
  4. Else, if counter == `HALF[note_idx]`: counter←0 and `speaker` toggles. Otherwise counter increments.
- Re-pressing the currently sounding key, with no other change, counts as a press. It restarts the counter.
- Counter compare is unsigned. The counter never exceeds the table value, because every note change clears it.

## Timing
- **Reset:** `rst_n` low forces, immediately and asynchronously:
  - `speaker`=0, `active`=0, `note_idx`=0;
  - counter=0, state=IDLE;
  - `ks1`=`ks2`=`ks_d`=0.
- **Release from reset:** synchronous to the next `clk` edge. A key held through reset is seen as a new press about 3 cycles after release.
- **Key-to-output latency:**
  - A key change stable before edge N appears on `ks2` after edge N+1.
  - `active`/`note_idx` update on edge N+2.
- **First toggle:** the first `speaker` toggle occurs `HALF[note_idx]`+1 cycles after the PLAY entry edge.
- **Output frequency:** 50e6 / (2·(`HALF`+1)) Hz.
- **Simultaneous presses in one cycle:** the highest index wins.
- **Press and release of other keys in the same cycle:** the press wins (rule 2 before rule 3).
- **Key bounce:** no debounce in this block. Each synchronized rising edge is a press.

## Test plan
- **Reset:** hold `rst_n`=0 with `keys`=8'hFF → `speaker`=0, `active`=0, `note_idx`=0. Release → PLAY with `note_idx`=7 within 3 cycles.
- **Single note:** press key 5 only → `active` rises 2 edges after the input change, `note_idx`=5. `speaker` period is 113636 cycles (half = 56818).
- **Last-pressed priority:** hold key 0, then press key 3 → `note_idx`=3, counter restarts. Release key 3 → `note_idx`=0.
- **Simultaneous press:** keys 1 and 6 rise in the same cycle → `note_idx`=6. Release key 6 → `note_idx`=1, half-period 85132 cycles.
- **All released:** release all keys mid half-period → IDLE two edges later, `speaker`=0, `active`=0.
- **Reset mid-note:** assert `rst_n` asynchronously (between `clk` edges) while `speaker`=1 → `speaker` drops without waiting for `clk`. After release with keys held, the first toggle comes `HALF`+1 cycles after PLAY entry.
